// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, alu select legality check and FSM state encoding for alu_share_arbiter
package alu_pkg;

    localparam logic [2:0] ALUC_SEL_ADDSUB = 3'd0;
    localparam logic [2:0] ALUC_SEL_ANDOR  = 3'd2;
    localparam logic [2:0] ALUC_SEL_XORLUI = 3'd4;
    localparam logic [2:0] ALUC_SEL_SHIFT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic aluc_legal(input logic [2:0] sel);
        return sel inside {ALUC_SEL_ADDSUB, ALUC_SEL_ANDOR, ALUC_SEL_XORLUI, ALUC_SEL_SHIFT};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr, wrapping modulo NREQ
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // scan ptr+1 .. ptr+NREQ and keep the first hit; gnt only asserts when enabled
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        if (en && any) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external alu among NREQ requesters; ALU_ARB_STATS_EN adds grant counters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              clrn,
`ifdef ALU_ARB_STATS_EN
    input  logic [IDW-1:0]    stat_sel,
    input  logic              stat_clr,
    output logic [15:0]       stat_count,
`endif
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*6-1:0] req_aluc,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [5:0]        alu_aluc,
    input  logic [31:0]       alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [IDW-1:0]    out_id,
    output logic              out_err
);

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_id;
    logic [31:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [5:0]     aluc_q, aluc_d;
    logic           err_q, err_d, any, en, acc, legal;

    // a new op may be granted when idle, or when the current result is being taken this cycle
    assign en    = clrn && (state_q == ST_IDLE || (state_q == ST_RESP && out_ready));
    assign acc   = en && any;
    assign legal = aluc_legal(aluc_q[2:0]);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (en),
        .gnt    (req_ready),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_aluc   = aluc_q;
    assign out_valid  = state_q == ST_RESP;
    assign out_result = res_q;
    assign out_id     = id_q;
    assign out_err    = err_q;

    // next state: accept latches operands, EXEC captures the alu result, RESP waits for the consumer
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        aluc_d   = aluc_q;
        id_d     = id_q;
        res_d    = res_q;
        err_d    = err_q;
        if (acc) begin
            a_d      = req_a[32*int'(gnt_id) +: 32];
            b_d      = req_b[32*int'(gnt_id) +: 32];
            aluc_d   = req_aluc[6*int'(gnt_id) +: 6];
            id_d     = gnt_id;
            rr_ptr_d = gnt_id;
            state_d  = ST_EXEC;
        end else if (state_q == ST_EXEC) begin
            res_d   = legal ? alu_result : 32'd0;
            err_d   = !legal;
            state_d = ST_RESP;
        end else if (state_q == ST_RESP && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    // state and datapath registers; reset points rr_ptr at the last requester so req 0 wins first
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= IDW'(NREQ - 1);
            a_q      <= '0;
            b_q      <= '0;
            aluc_q   <= '0;
            id_q     <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluc_q   <= aluc_d;
            id_q     <= id_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    // saturating per-requester grant counters; a clear beats a same-cycle increment
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            cnt_d[i] = stat_clr ? 16'd0
                     : (acc && gnt_id == IDW'(i) && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1
                     : cnt_q[i];
    end

    // counter registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign stat_count = (int'(stat_sel) < NREQ) ? cnt_q[stat_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed tests with a transaction-level model of the shared-alu arbiter
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk, clrn;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [NREQ*6-1:0] req_aluc;
    logic [31:0]       alu_a, alu_b, alu_result, out_result;
    logic [5:0]        alu_aluc;
    logic              out_valid, out_ready, out_err;
    logic [IDW-1:0]    out_id;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_aluc   (req_aluc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_aluc   (alu_aluc),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_id     (out_id),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external alu stand-in; illegal selects give a nonzero value so the arbiter must zero them
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
        logic signed [31:0] sra;
        sra = $signed(a) >>> b[4:0];
        case (c[2:0])
            3'd0:    return c[3] ? a - b : a + b;
            3'd2:    return c[3] ? a | b : a & b;
            3'd4:    return c[3] ? {b[15:0], 16'h0000} : a ^ b;
            3'd5:    return !c[3] ? a << b[4:0] : (c[4] ? sra : a >> b[4:0]);
            default: return a + b + 32'd1;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_aluc);

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0]    a, b, res;
        logic [5:0]     c;
        logic [IDW-1:0] id;
        logic           err;
        int             cyc;
    } op_t;

    op_t             q[$];
    op_t             m_op;
    int              cyc    = 0;
    int              last_g = NREQ - 1;
    int              m_g;
    logic            m_ev, m_slot;
    logic [NREQ-1:0] m_er;

    // model: ops in flight in a queue; result visible two cycles after accept, held until taken
    always @(negedge clk) begin
        cyc++;
        if (!clrn) begin
            q.delete();
            last_g = NREQ - 1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_out_result", out_result, 32'd0);
        end else begin
            m_ev = q.size() > 0 && cyc >= q[0].cyc + 2;
            chk("out_valid", 32'(out_valid), 32'(m_ev));
            if (q.size() > 0) begin
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("alu_aluc", 32'(alu_aluc), 32'(q[0].c));
            end
            if (m_ev) begin
                chk("out_result", out_result, q[0].res);
                chk("out_id", 32'(out_id), 32'(q[0].id));
                chk("out_err", 32'(out_err), 32'(q[0].err));
            end
            m_slot = q.size() == 0 || (m_ev && out_ready);
            m_g = -1;
            for (int k = 1; k <= NREQ; k++)
                if (m_g < 0 && req_valid[(last_g + k) % NREQ]) m_g = (last_g + k) % NREQ;
            m_er = '0;
            if (m_slot && m_g >= 0) m_er[m_g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(m_er));
            if (m_ev && out_ready) void'(q.pop_front());
            if (m_slot && m_g >= 0) begin
                m_op.a   = req_a[32*m_g +: 32];
                m_op.b   = req_b[32*m_g +: 32];
                m_op.c   = req_aluc[6*m_g +: 6];
                m_op.err = !(m_op.c[2:0] inside {3'd0, 3'd2, 3'd4, 3'd5});
                m_op.res = m_op.err ? 32'd0 : alu_f(m_op.a, m_op.b, m_op.c);
                m_op.id  = IDW'(m_g);
                m_op.cyc = cyc;
                q.push_back(m_op);
                last_g = m_g;
            end
        end
    end

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_aluc[6*r +: 6] = c;
    endtask

    task automatic wait_ready(input string nm, output int g);
        int n = 0;
        g = -1;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == '0) chk(nm, 32'(req_ready), 32'd1);
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk(nm, 32'(out_valid), 32'd1);
    endtask

    task automatic do_op(input string nm, input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c, input logic [31:0] er, input int eid, input logic ee);
        int g;
        set_req(r, a, b, c);
        out_ready    = 1'b1;
        req_valid[r] = 1'b1;
        wait_ready({nm, "_acc"}, g);
        chk({nm, "_grant"}, 32'(g), 32'(r));
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        wait_valid({nm, "_timeout"});
        chk({nm, "_res"}, out_result, er);
        chk({nm, "_id"}, 32'(out_id), 32'(eid));
        chk({nm, "_err"}, 32'(out_err), 32'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1);
    end

    int   g, t, n;
    int   gc[4];
    logic [31:0] gid[4];

    initial begin
        clrn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_aluc = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        // T1 / T2
        do_op("t1_add", 0, 32'd5, 32'd7, 6'b000000, 32'd12, 0, 1'b0);
        do_op("t2_sra", 1, 32'h80000000, 32'd4, 6'b011101, 32'hF8000000, 1, 1'b0);
        do_op("t2_sub", 1, 32'd3, 32'd5, 6'b001000, 32'hFFFFFFFE, 1, 1'b0);
        // T3 fairness
        set_req(0, 32'd100, 32'd1, 6'b000000);
        set_req(1, 32'd100, 32'd1, 6'b001000);
        out_ready = 1'b1;
        req_valid = 2'b11;
        n = 0; t = 0;
        while (n < 4 && t < 40) begin
            @(negedge clk);
            t++;
            if (req_ready != '0) begin
                gid[n] = 32'(req_ready[1]);
                gc[n]  = t;
                n++;
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        chk("t3_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_grant", gid[i], 32'(i % 2));
        for (int i = 1; i < 4; i++) chk("t3_gap", 32'(gc[i] - gc[i-1]), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        // T4 backpressure
        out_ready = 1'b0;
        set_req(0, 32'd10, 32'd20, 6'b000000);
        set_req(1, 32'h000000F0, 32'h0000003C, 6'b000010);
        req_valid = 2'b11;
        wait_ready("t4_acc", g);
        chk("t4_first", 32'(g), 32'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_valid("t4_timeout");
        repeat (5) begin
            chk("t4_ready_low", 32'(req_ready), 32'd0);
            chk("t4_res_stable", out_result, 32'd30);
            chk("t4_id_stable", 32'(out_id), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("t4_same_cycle", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1 req_valid = '0;
        wait_valid("t4b_timeout");
        chk("t4b_res", out_result, 32'h00000030);
        chk("t4b_id", 32'(out_id), 32'd1);
        @(posedge clk);
        #1;
        // T5 illegal then legal
        do_op("t5_illegal", 0, 32'd1, 32'd1, 6'b000011, 32'd0, 0, 1'b1);
        do_op("t5_legal", 0, 32'd2, 32'd3, 6'b000000, 32'd5, 0, 1'b0);
        // T6 reset during EXEC
        set_req(0, 32'd1, 32'd2, 6'b000000);
        set_req(1, 32'd7, 32'd7, 6'b000000);
        req_valid = 2'b01;
        wait_ready("t6_acc", g);
        @(posedge clk);
        #1 req_valid = 2'b11;
        #1 clrn = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_result", out_result, 32'd0);
        chk("t6_err", 32'(out_err), 32'd0);
        chk("t6_alu_a", alu_a, 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 clrn = 1'b1;
        @(negedge clk);
        chk("t6_first", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_valid("t6_timeout");
        chk("t6_res", out_result, 32'd3);
        chk("t6_id", 32'(out_id), 32'd0);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
